// File: rtl/bidir_shift_rx.sv
// ---------------------------------------------------------------------------
// bidir_shift_rx
//   Serial-to-parallel receiver for the bidirectional shift-register link.
//   Samples i_sin on every clock where i_sin_en=1 and rebuilds a WIDTH-bit
//   word in LSB-first (i_ctrl=1) or MSB-first (i_ctrl=0) order. The order is
//   latched on the first bit of each word. Completed words are offered on a
//   valid/ready port; a word that completes while the port is still full is
//   dropped and the sticky o_overrun flag is raised.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_sin        serial data bit
//   i_sin_en     qualifies i_sin
//   i_ctrl       bit order: 1 = LSB-first, 0 = MSB-first
//   i_clr        synchronous abort of a partial word (output side untouched)
//   o_out_data   received word
//   o_out_valid  o_out_data holds an unconsumed word
//   i_out_ready  consumer accepts when o_out_valid && i_out_ready
//   o_overrun    sticky: a completed word was dropped (cleared by reset only)
//   o_busy       a partial word is in progress
//
// States
//   S_IDLE | no partial word; the next qualified bit is bit 0 of a new word
//   S_RECV | 1..WIDTH-1 bits collected, order latched in r_dir
// ---------------------------------------------------------------------------
module bidir_shift_rx #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sin,
  input  logic             i_sin_en,
  input  logic             i_ctrl,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_overrun,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [WIDTH-1:0] w_sr_ins;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_dir;
  logic             w_dir_nxt;
  logic             w_bit_dir;
  logic             w_take;
  logic             w_complete;
  logic             w_slot_free;

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_overrun;

  // Datapath decode shared by the FSM and the output slot.
  always_comb begin
    w_take      = i_sin_en && !i_clr;
    // The first bit of a word uses the live i_ctrl; later bits use the
    // latched order so mid-word i_ctrl changes have no effect.
    w_bit_dir   = (r_state == S_IDLE) ? i_ctrl : r_dir;
    w_sr_ins    = w_bit_dir ? {i_sin, r_sr[WIDTH-1:1]}
                            : {r_sr[WIDTH-2:0], i_sin};
    w_complete  = w_take && (r_state == S_RECV) && (r_cnt == LAST_IDX);
    w_slot_free = !r_out_valid || i_out_ready;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    if (i_clr) begin
      // Abort wins over any bit presented on the same edge.
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_sin_en) begin
            w_dir_nxt   = i_ctrl;
            w_sr_nxt    = w_sr_ins;
            w_cnt_nxt   = CW'(1);
            w_state_nxt = S_RECV;
          end
        end
        S_RECV: begin
          if (i_sin_en) begin
            w_sr_nxt = w_sr_ins;
            if (r_cnt == LAST_IDX) begin
              w_cnt_nxt   = '0;
              w_state_nxt = S_IDLE;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output slot. Accept and reload on the same edge keeps valid high and
  // takes the new word; a completion into a full slot is dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_complete) begin
        if (w_slot_free) begin
          r_out_data  <= w_sr_ins;
          r_out_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_overrun   = r_overrun;
  assign o_busy      = (r_state == S_RECV);

endmodule

// File: doc/bidir_shift_rx.md
# bidir_shift_rx

Serial-to-parallel receiver for the 4-bit bidirectional shift-register serial link. It samples `sin` one bit per qualified clock and rebuilds the word in either bit order: LSB-first for right-shift mode, MSB-first for left-shift mode. Completed words are presented on a valid/ready output port with overrun detection. It sits at the far end of the serial line, opposite the bidirectional shift register.

## Interface
- `WIDTH`, default 4: word length in bits; legal range is 2 or more.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `sin`  input  1  serial data bit.
- `sin_en`  input  1  qualifies `sin`; a bit is sampled only on edges where `sin_en`=1.
- `ctrl`  input  1  bit order.
  - 1: LSB-first (transmitter right-shifting).
  - 0: MSB-first (transmitter left-shifting).
- `clr`  input  1  synchronous abort of a partial word. It does not touch the output register or `overrun`.
- `out_data`  output  WIDTH  received word.
- `out_valid`  output  1  `out_data` holds an unconsumed word.
- `out_ready`  input  1  consumer accepts the word when `out_valid`&&`out_ready`.
- `overrun`  output  1  sticky: a completed word was dropped because the output was still full.
- `busy`  output  1  a partial word is in progress (state RECV).

## Operation
- Internal state:
  - shift register `sr[WIDTH-1:0]`;
  - bit counter `cnt`, width $clog2(WIDTH), counting 0..WIDTH-1;
  - latched order bit `dir`;
  - FSM states IDLE and RECV.
- IDLE:
  - On `sin_en`=1, latch `dir`<=`ctrl`, insert the first bit, set `cnt`<=1 and go to RECV.
  - With `sin_en`=0 there is no change.
- Bit insertion uses the order in force for the current bit.
  - Order 1 (LSB-first): `sr`<={`sin`, `sr`[WIDTH-1:1]}.
  - Order 0 (MSB-first): `sr`<={`sr`[WIDTH-2:0], `sin`}.
- RECV:
  - Each `sin_en`=1 inserts a bit using the latched `dir` and increments `cnt`.
  - `ctrl` changes mid-word are ignored.
- Word completion happens on the edge that samples bit number WIDTH (`cnt`==WIDTH-1 and `sin_en`=1).
  - The assembled word, including that final bit, is loaded into `out_data` if the output slot is free.
  - `cnt`<=0 and the FSM returns to IDLE.
  - A following bit on the very next cycle starts a new word: back-to-back words run with no gap cycles.
- The output slot is free when `out_valid`=0, or when `out_valid`&&`out_ready` on the same edge.
  - Accept and reload on the same edge is legal: `out_valid` stays 1 and `out_data` takes the new word.
- Completion while the slot is not free:
  - The new word is discarded and `overrun`<=1.
  - `out_data`/`out_valid` keep the old word.
- `out_valid` clears on any edge with `out_valid`&&`out_ready` and no simultaneous completion.
- `overrun` clears only on reset.
- `clr`=1:
  - `cnt`<=0 and FSM<=IDLE; any bit presented that cycle is ignored.
  - `clr` has priority over `sin_en`.
  - The output handshake still proceeds normally on that edge.
- `busy` = (state==RECV).

## Timing
- Reset (`rst_n`=0, asynchronous) values:
  - `sr`=0, `cnt`=0, `dir`=0, state=IDLE;
  - `out_data`=0, `out_valid`=0, `overrun`=0, `busy`=0.
- Reset assertion mid-word discards the partial word and any pending output immediately, with no clock required.
- After deassertion, the first `sin_en`=1 edge is bit 0 of a new word.
- Latency: `out_valid` rises at the same clock edge that samples the last bit. It is visible in the cycle after that edge, so the minimum word period is WIDTH clocks.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- All outputs are registered. There are no combinational paths from inputs to outputs, except `busy`, which is decoded from the state register.

## Test plan
- Reset, then LSB-first order:
  - Stimulus: `ctrl`=1, `sin_en`=1, `sin`=1,0,1,1 on 4 consecutive edges, `out_ready`=1.
  - Response: `out_data`=4'b1101, `out_valid`=1 for exactly one cycle, `busy` high for 3 cycles.
- MSB-first order:
  - Stimulus: `ctrl`=0, `sin`=1,0,1,1.
  - Response: `out_data`=4'b1011.
  - Also: toggle `ctrl` to 1 after bit 1; `out_data` is still 4'b1011.
- Gaps and abort:
  - Stimulus: `sin_en` low between bits (pattern 1,x,0,x,x,1,1 with x=`sin_en`=0, LSB-first).
  - Response: `out_data`=4'b1101.
  - Also: `clr` after 2 bits, then 4 new bits 0,0,0,1 LSB-first gives 4'b1000.
- Back-to-back words and overrun:
  - Stimulus: LSB-first words 4'hA then 4'h5 streamed continuously, `out_ready`=0.
  - Response: `out_data`=4'hA held, `overrun`=1 after the 8th bit.
  - Then: raise `out_ready`; `out_valid` falls next edge and `overrun` stays 1.
- Simultaneous accept and completion:
  - Stimulus: `out_valid`=1 holding 4'h3, `out_ready`=1 on the edge the last bit of 4'hC arrives.
  - Response: `out_valid` stays 1, `out_data`=4'hC, `overrun`=0.
- Asynchronous reset mid-word:
  - Stimulus: assert `rst_n`=0 between clock edges after 2 bits, with `out_valid`=1.
  - Response: all outputs go to 0 immediately.
  - Then: the next 4 bits 1,1,1,1 give `out_data`=4'hF.
